// File: rtl/arbiter_age_n.sv
// -----------------------------------------------------------------------------
// arbiter_age_n
//   N-way age-ordered arbiter in front of a shared downstream buffer.
//   Requests are served strictly in arrival order. Requests that arrive in
//   the same cycle form one age group. Within a group the lowest index wins,
//   unless the round-robin tie-break is compiled in.
//
//   Optional feature macro: ARBITER_RR_EN
//     defined   - a 'last granted' pointer selects within a group, round-robin.
//     undefined - within-group selection is fixed lowest-index.
//
// Parameters
//   N      number of requesters (>= 2)
//   DEPTH  number of stored age groups (1..N)
//
// Ports
//   clk            clock
//   rst            synchronous active-high reset
//   request[N]     level request per requester
//   buffer_full_i  downstream full, suppresses the grant
//   grant[N]       one-hot grant, or zero (combinational)
//   grant_v_o      a grant is valid this cycle (combinational)
//   pending_o      number of requesters held in the registered queue
// -----------------------------------------------------------------------------
module arbiter_age_n #(
  parameter int N     = 4,
  parameter int DEPTH = N
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           request,
  input  logic                   buffer_full_i,
  output logic [N-1:0]           grant,
  output logic                   grant_v_o,
  output logic [$clog2(N+1)-1:0] pending_o
);

  localparam int PW = $clog2(N+1);
  localparam int IW = $clog2(DEPTH+1);

  typedef logic [N-1:0] vec_t;

  // Stored groups are always compacted: nonempty groups sit at the low
  // indices and every unused slot holds zero, so no separate count is kept.
  vec_t          groups_q [DEPTH];
  vec_t          groups_d [DEPTH];
  vec_t          eff      [DEPTH+1];  // compacted, withdrawn groups + arrivals
  vec_t          comp     [DEPTH+1];  // eff minus the granted bit, compacted
  vec_t          tracked;
  vec_t          arrival;
  vec_t          cand;
  vec_t          pick;
  logic          found;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] cmp_idx;
  logic [PW-1:0] pend_cnt;

  // Effective queue: mask stored groups with request (withdrawal), squeeze
  // out the groups that became empty, then append the arrival group.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so
    // no path leaves it holding its old value and no latch is inferred.
    tracked = '0;
    for (int i = 0; i < DEPTH; i++) tracked |= groups_q[i];
    arrival = request & ~tracked;
    for (int j = 0; j <= DEPTH; j++) eff[j] = '0;
    wr_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((groups_q[i] & request) != '0) begin
        eff[wr_idx] = groups_q[i] & request;
        wr_idx      = wr_idx + IW'(1);
      end
    end
    eff[wr_idx] = arrival;
  end

  // Because eff is compacted, eff[0] is always the first nonempty group.
`ifdef ARBITER_RR_EN
  localparam int LW = $clog2(N);

  logic [LW-1:0] last_q;
  logic [LW-1:0] grant_idx;

  // First set bit above the last granted index, otherwise wrap to the lowest.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && eff[0][i] && (LW'(i) > last_q)) begin
        pick[i] = 1'b1;
        found   = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && eff[0][i]) begin
        pick[i] = 1'b1;
        found   = 1'b1;
      end
    end
  end

  always_comb begin
    grant_idx = last_q;
    for (int i = 0; i < N; i++) if (grant[i]) grant_idx = LW'(i);
  end

  always_ff @(posedge clk) begin
    if (rst)            last_q <= LW'(N-1);
    else if (grant_v_o) last_q <= grant_idx;
  end
`else
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && eff[0][i]) begin
        pick[i] = 1'b1;
        found   = 1'b1;
      end
    end
  end
`endif

  assign grant     = (rst || buffer_full_i) ? '0 : pick;
  assign grant_v_o = |grant;

  // Next state: drop the granted bit, compact again, and fold any group that
  // does not fit into the youngest stored slot so no request is lost.
  always_comb begin
    for (int j = 0; j <= DEPTH; j++) comp[j] = '0;
    cmp_idx = '0;
    cand    = '0;
    for (int j = 0; j <= DEPTH; j++) begin
      cand = (j == 0) ? (eff[0] & ~grant) : eff[j];
      if (cand != '0) begin
        comp[cmp_idx] = cand;
        cmp_idx       = cmp_idx + IW'(1);
      end
    end
    for (int i = 0; i < DEPTH - 1; i++) groups_d[i] = comp[i];
    groups_d[DEPTH-1] = comp[DEPTH-1] | comp[DEPTH];
  end

  always_comb begin
    pend_cnt = '0;
    for (int i = 0; i < DEPTH; i++)
      for (int b = 0; b < N; b++) pend_cnt = pend_cnt + PW'(groups_q[i][b]);
    pending_o = rst ? '0 : pend_cnt;
  end

  always_ff @(posedge clk) begin
    // NOTE: the group registers are reset explicitly; an uncleared slot would
    // look like a queued request and break the compaction invariant.
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) groups_q[i] <= '0;
    end else begin
      // NOTE: non-blocking so every slot loads the pre-edge next state.
      for (int i = 0; i < DEPTH; i++) groups_q[i] <= groups_d[i];
    end
  end

endmodule

// File: tb/tb_arbiter_age_n.sv
// -----------------------------------------------------------------------------
// tb_arbiter_age_n
//   Directed self-checking bench for arbiter_age_n. Instance dut uses N=4,
//   DEPTH=4; instance dut2 uses N=4, DEPTH=2 for the overflow-merge case.
//   Inputs change one time unit after a rising edge; outputs are sampled one
//   further unit later, well before the next edge.
// -----------------------------------------------------------------------------
module tb_arbiter_age_n;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] request;
  logic       buffer_full_i;

  logic [3:0] g1, g2;
  logic       v1, v2;
  logic [2:0] p1, p2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  arbiter_age_n #(.N(4), .DEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .request       (request),
    .buffer_full_i (buffer_full_i),
    .grant         (g1),
    .grant_v_o     (v1),
    .pending_o     (p1)
  );

  arbiter_age_n #(.N(4), .DEPTH(2)) dut2 (
    .clk           (clk),
    .rst           (rst),
    .request       (request),
    .buffer_full_i (buffer_full_i),
    .grant         (g2),
    .grant_v_o     (v2),
    .pending_o     (p2)
  );

  // Advance past the next rising edge; inputs may then be changed.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    request       = 4'b0000;
    buffer_full_i = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    request       = 4'b1111;
    buffer_full_i = 1'b0;
    #1;
    checks++;
    if (g1 !== 4'b0000 || v1 !== 1'b0) begin
      $display("FAIL reset_grant_pre_edge got=%b/%b exp=0000/0", g1, v1);
      failures++;
    end
    checks++;
    if (p1 !== 3'd0) begin
      $display("FAIL reset_pending_pre_edge got=%0d exp=0", p1);
      failures++;
    end
    step();
    checks++;
    if (g1 !== 4'b0000 || v1 !== 1'b0 || p1 !== 3'd0) begin
      $display("FAIL reset_held got=%b/%b/%0d exp=0000/0/0", g1, v1, p1);
      failures++;
    end
    step();
    rst     = 1'b0;
    request = 4'b0000;
    #1;
    checks++;
    if (v1 !== 1'b0 || p1 !== 3'd0) begin
      $display("FAIL reset_empty_after got=%b/%0d exp=0/0", v1, p1);
      failures++;
    end
  endtask

  // Scenario 1: held 0011 alternates between the two requesters.
  task automatic test_held();
    logic [3:0] exp_g [4];
    exp_g = '{4'b0001, 4'b0010, 4'b0001, 4'b0010};
    do_reset();
    request = 4'b0011;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (g1 !== exp_g[c] || v1 !== 1'b1) begin
        $display("FAIL held_grant c=%0d got=%b/%b exp=%b/1", c, g1, v1, exp_g[c]);
        failures++;
      end
      if (c >= 1) begin
        checks++;
        if (p1 !== 3'd1) begin
          $display("FAIL held_pending c=%0d got=%0d exp=1", c, p1);
          failures++;
        end
      end
      step();
    end
  endtask

  // Scenario 2: an older request queued under backpressure wins first.
  task automatic test_age();
    do_reset();
    request       = 4'b1000;
    buffer_full_i = 1'b1;
    #1;
    checks++;
    if (g1 !== 4'b0000 || v1 !== 1'b0) begin
      $display("FAIL age_backpressure got=%b/%b exp=0000/0", g1, v1);
      failures++;
    end
    step();
    request       = 4'b1001;
    buffer_full_i = 1'b0;
    #1;
    checks++;
    if (p1 !== 3'd1) begin
      $display("FAIL age_pending got=%0d exp=1", p1);
      failures++;
    end
    checks++;
    if (g1 !== 4'b1000) begin
      $display("FAIL age_first got=%b exp=1000", g1);
      failures++;
    end
    step();
    request = 4'b0001;
    #1;
    checks++;
    if (g1 !== 4'b0001) begin
      $display("FAIL age_second got=%b exp=0001", g1);
      failures++;
    end
    step();
    request = 4'b0000;
    #1;
    checks++;
    if (p1 !== 3'd0 || v1 !== 1'b0) begin
      $display("FAIL age_drained got=%0d/%b exp=0/0", p1, v1);
      failures++;
    end
  endtask

  // Scenario 3: the oldest group withdraws; the next group is granted at once.
  task automatic test_withdraw();
    do_reset();
    buffer_full_i = 1'b1;
    request       = 4'b0100;
    step();
    request = 4'b0110;
    step();
    #1;
    checks++;
    if (p1 !== 3'd2) begin
      $display("FAIL withdraw_pending_before got=%0d exp=2", p1);
      failures++;
    end
    request       = 4'b0010;
    buffer_full_i = 1'b0;
    #1;
    checks++;
    if (g1 !== 4'b0010 || v1 !== 1'b1) begin
      $display("FAIL withdraw_grant got=%b/%b exp=0010/1", g1, v1);
      failures++;
    end
    step();
    request = 4'b0000;
    #1;
    checks++;
    if (p1 !== 3'd0) begin
      $display("FAIL withdraw_pending_after got=%0d exp=0", p1);
      failures++;
    end
  endtask

  // Scenario 4: DEPTH=2, third group merges into the youngest slot.
  task automatic test_overflow();
    logic [3:0] exp_g [4];
`ifdef ARBITER_RR_EN
    exp_g = '{4'b0100, 4'b1000, 4'b0001, 4'b0010};
`else
    exp_g = '{4'b0100, 4'b0001, 4'b0010, 4'b1000};
`endif
    do_reset();
    buffer_full_i = 1'b1;
    request       = 4'b0100;
    step();
    request = 4'b0110;
    step();
    request = 4'b1111;
    #1;
    checks++;
    if (g2 !== 4'b0000 || v2 !== 1'b0) begin
      $display("FAIL overflow_backpressure got=%b/%b exp=0000/0", g2, v2);
      failures++;
    end
    step();
    #1;
    checks++;
    if (p2 !== 3'd4) begin
      $display("FAIL overflow_pending got=%0d exp=4", p2);
      failures++;
    end
    buffer_full_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (g2 !== exp_g[c] || v2 !== 1'b1) begin
        $display("FAIL overflow_grant c=%0d got=%b/%b exp=%b/1", c, g2, v2, exp_g[c]);
        failures++;
      end
      step();
      request = request & ~exp_g[c];
    end
    #1;
    checks++;
    if (p2 !== 3'd0 || v2 !== 1'b0) begin
      $display("FAIL overflow_drained got=%0d/%b exp=0/0", p2, v2);
      failures++;
    end
  endtask

  // Scenario 5: reset discards age; held requests form a single new group.
  task automatic test_reset_mid();
    do_reset();
    buffer_full_i = 1'b1;
    request       = 4'b1000;
    step();
    request = 4'b1001;
    step();
    #1;
    checks++;
    if (p1 !== 3'd2) begin
      $display("FAIL rstmid_pending_before got=%0d exp=2", p1);
      failures++;
    end
    rst           = 1'b1;
    buffer_full_i = 1'b0;
    #1;
    checks++;
    if (g1 !== 4'b0000 || v1 !== 1'b0 || p1 !== 3'd0) begin
      $display("FAIL rstmid_during got=%b/%b/%0d exp=0000/0/0", g1, v1, p1);
      failures++;
    end
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (g1 !== 4'b0001) begin
      $display("FAIL rstmid_first got=%b exp=0001", g1);
      failures++;
    end
    step();
    request = 4'b1000;
    #1;
    checks++;
    if (g1 !== 4'b1000) begin
      $display("FAIL rstmid_second got=%b exp=1000", g1);
      failures++;
    end
    step();
    request = 4'b0000;
  endtask

  // Scenario 6: within-group selection after requester 2 was last granted.
  task automatic test_tie_break();
    logic [3:0] exp_first;
    logic [3:0] exp_second;
`ifdef ARBITER_RR_EN
    exp_first  = 4'b1000;
    exp_second = 4'b0001;
`else
    exp_first  = 4'b0001;
    exp_second = 4'b1000;
`endif
    do_reset();
    request = 4'b0100;
    #1;
    checks++;
    if (g1 !== 4'b0100) begin
      $display("FAIL tie_setup got=%b exp=0100", g1);
      failures++;
    end
    step();
    request = 4'b1001;
    #1;
    checks++;
    if (g1 !== exp_first) begin
      $display("FAIL tie_first got=%b exp=%b", g1, exp_first);
      failures++;
    end
    step();
    request = request & ~exp_first;
    #1;
    checks++;
    if (g1 !== exp_second) begin
      $display("FAIL tie_second got=%b exp=%b", g1, exp_second);
      failures++;
    end
    step();
    request = 4'b0000;
  endtask

  // Continuous contention: one grant every cycle, queue never empties.
  task automatic test_back_to_back();
    do_reset();
    request = 4'b1111;
    for (int c = 0; c < 6; c++) begin
      #1;
      checks++;
      if (v1 !== 1'b1 || $countones(g1) != 1) begin
        $display("FAIL b2b_one_hot c=%0d got=%b/%b exp=onehot/1", c, g1, v1);
        failures++;
      end
      step();
    end
    #1;
    checks++;
    if (p1 !== 3'd3) begin
      $display("FAIL b2b_pending got=%0d exp=3", p1);
      failures++;
    end
    request = 4'b0000;
    step();
  endtask

  initial begin
    test_reset();
    test_held();
    test_age();
    test_withdraw();
    test_overflow();
    test_reset_mid();
    test_tie_break();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
